// File: rtl/rr_mux_arbiter_4_pkg.sv
// rr_mux_pkg: shared constants and types for the 4-way round-robin mux arbiter.
//   N_REQ : number of requesters
//   SEL_W : width of a requester index (ptr, out_sel)
//   sel_t : requester index type; all arithmetic on it wraps modulo N_REQ
package rr_mux_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_mux_arbiter_4_if.sv
// rr_mux_arbiter_4_if: bundle of the four requester streams and the single
// output stream of rr_mux_arbiter_4.
//   in_valid[3:0]     requester i has data
//   in_data0..3       requester data
//   in_ready[3:0]     requester i accepted this cycle (one-hot or zero)
//   out_valid         output register holds a transfer
//   out_data          data of the granted requester
//   out_sel           index of the requester that produced out_data
//   out_ready         consumer accepts the output this cycle
// Modports: master = producers/consumer side, slave = arbiter side.
interface rr_mux_arbiter_4_if
    import rr_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) ();

    logic [N_REQ-1:0] in_valid;
    logic [WIDTH-1:0] in_data0;
    logic [WIDTH-1:0] in_data1;
    logic [WIDTH-1:0] in_data2;
    logic [WIDTH-1:0] in_data3;
    logic [N_REQ-1:0] in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    sel_t             out_sel;
    logic             out_ready;

    modport master (
        output in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/rr_mux_arbiter_4_grant.sv
// rr_grant_4: combinational round-robin grant for four requesters.
//   req[3:0]          request vector
//   ptr               highest-priority requester index
//   grant_onehot[3:0] one-hot grant, zero when no request
//   g                 index of the granted requester (0 when none)
//   any_req           at least one request is present
module rr_grant_4
    import rr_mux_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             ptr,
    output logic [N_REQ-1:0] grant_onehot,
    output sel_t             g,
    output logic             any_req
);

    always_comb begin
        sel_t idx;
        idx          = '0;
        grant_onehot = '0;
        g            = '0;
        any_req      = 1'b0;
        // Scan ptr, ptr+1, ... ; sel_t addition wraps 3 -> 0 on its own.
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ptr + sel_t'(k);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                g       = idx;
            end
        end
        grant_onehot[g] = any_req;
    end

endmodule

// File: rtl/rr_mux_arbiter_4.sv
// rr_mux_arbiter_4: four valid/ready requesters share one AND-OR mux into a
// single registered valid/ready output stream, arbitrated round-robin.
// One transfer per cycle, one cycle of latency.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    rr_mux_arbiter_4_if.slave (requester and output streams)
module rr_mux_arbiter_4
    import rr_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    rr_mux_arbiter_4_if.slave bus
);

    logic [N_REQ-1:0] grant_onehot;
    sel_t             g;
    logic             any_req;
    sel_t             ptr_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    sel_t             out_sel_q;
    logic             load_en;
    logic [WIDTH-1:0] data_arr [N_REQ];
    logic [WIDTH-1:0] mux_data;

    rr_grant_4 u_grant (
        .req          (bus.in_valid),
        .ptr          (ptr_q),
        .grant_onehot (grant_onehot),
        .g            (g),
        .any_req      (any_req)
    );

    assign data_arr[0] = bus.in_data0;
    assign data_arr[1] = bus.in_data1;
    assign data_arr[2] = bus.in_data2;
    assign data_arr[3] = bus.in_data3;

    // Output slot is free when empty or being drained this cycle.
    assign load_en = ~out_valid_q | bus.out_ready;

    // AND-OR mux: each input masked by its replicated grant bit.
    always_comb begin
        mux_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            mux_data = mux_data | (data_arr[i] & {WIDTH{grant_onehot[i]}});
        end
    end

    assign bus.in_ready = (rst_n && load_en) ? grant_onehot : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else if (load_en) begin
            if (any_req) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mux_data;
                out_sel_q   <= g;
                ptr_q       <= g + sel_t'(1);
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// tb_rr_mux_arbiter_4: directed scenarios plus a randomized scoreboard run
// for rr_mux_arbiter_4, checked against a behavioural round-robin model.
module tb_rr_mux_arbiter_4;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_mux_arbiter_4_if #(.WIDTH(W)) bus ();

    rr_mux_arbiter_4 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int         m_ptr;
    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_sel;

    // Per-step observations (DUT values just before the edge) and model grant
    logic [3:0]   exp_ready;
    logic [3:0]   obs_ready;
    logic         obs_ovalid;
    logic [W-1:0] obs_odata;
    logic [1:0]   obs_osel;

    logic [W-1:0] da, db, dc, dd;

    typedef struct {
        int           sel;
        logic [W-1:0] data;
    } item_t;

    // One clock: drive at negedge, sample pre-edge DUT, advance model at posedge.
    task automatic step(input bit rst, input logic [3:0] v,
                        input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic [W-1:0] d2, input logic [W-1:0] d3,
                        input bit ordy);
        logic [W-1:0] d [4];
        int win;
        bit load;
        d = '{d0, d1, d2, d3};
        @(negedge clk);
        rst_n         = rst;
        bus.in_valid  = v;
        bus.in_data0  = d0;
        bus.in_data1  = d1;
        bus.in_data2  = d2;
        bus.in_data3  = d3;
        bus.out_ready = ordy;
        #1;
        obs_ready  = bus.in_ready;
        obs_ovalid = bus.out_valid;
        obs_odata  = bus.out_data;
        obs_osel   = bus.out_sel;
        win = -1;
        for (int k = 0; k < 4; k++)
            if (win < 0 && v[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        load = !m_valid || ordy;
        exp_ready = '0;
        if (rst && load && win >= 0) exp_ready[win] = 1'b1;
        @(posedge clk);
        if (!rst) begin
            m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
        end else if (load) begin
            if (win >= 0) begin
                m_valid = 1; m_data = d[win]; m_sel = win; m_ptr = (win + 1) % 4;
            end else begin
                m_valid = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(0, 4'b1111, da, db, dc, dd, 1);
        step(0, 4'b1111, da, db, dc, dd, 1);
        tests++; if (obs_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready: got %b expected 0000", obs_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        tests++; if (bus.out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
        tests++; if (bus.out_sel !== 2'd0) begin fails++; $display("FAIL reset_out_sel: got %0d expected 0", bus.out_sel); end
    endtask

    task automatic test_round_robin();
        logic [W-1:0] tab [4];
        tab = '{da, db, dc, dd};
        for (int k = 0; k < 5; k++) begin
            step(1, 4'b1111, da, db, dc, dd, 1);
            tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL rr_valid[%0d]: got %b expected 1", k, bus.out_valid); end
            tests++; if (bus.out_sel !== 2'(k % 4)) begin fails++; $display("FAIL rr_sel[%0d]: got %0d expected %0d", k, bus.out_sel, k % 4); end
            tests++; if (bus.out_data !== tab[k % 4]) begin fails++; $display("FAIL rr_data[%0d]: got %h expected %h", k, bus.out_data, tab[k % 4]); end
        end
    endtask

    task automatic test_wrap();
        step(1, 4'b0010, da, db, dc, dd, 1);
        tests++; if (bus.out_sel !== 2'd1) begin fails++; $display("FAIL wrap_pre_sel: got %0d expected 1", bus.out_sel); end
        step(1, 4'b0011, da, db, dc, dd, 1);
        tests++; if (obs_ready !== 4'b0001) begin fails++; $display("FAIL wrap_ready0: got %b expected 0001", obs_ready); end
        tests++; if (bus.out_sel !== 2'd0 || bus.out_data !== da) begin fails++; $display("FAIL wrap_sel0: got sel %0d data %h expected sel 0 data %h", bus.out_sel, bus.out_data, da); end
        step(1, 4'b0011, da, db, dc, dd, 1);
        tests++; if (bus.out_sel !== 2'd1 || bus.out_data !== db) begin fails++; $display("FAIL wrap_sel1: got sel %0d data %h expected sel 1 data %h", bus.out_sel, bus.out_data, db); end
    endtask

    task automatic test_backpressure();
        step(1, 4'b1111, da, db, dc, dd, 1);
        tests++; if (bus.out_sel !== 2'd2 || bus.out_data !== dc) begin fails++; $display("FAIL bp_load: got sel %0d data %h expected sel 2 data %h", bus.out_sel, bus.out_data, dc); end
        for (int k = 0; k < 3; k++) begin
            step(1, 4'b1111, da, db, dc, dd, 0);
            tests++; if (obs_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, obs_ready); end
            tests++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd2 || bus.out_data !== dc) begin fails++; $display("FAIL bp_hold[%0d]: got v%b sel %0d data %h expected v1 sel 2 data %h", k, bus.out_valid, bus.out_sel, bus.out_data, dc); end
        end
        step(1, 4'b1111, da, db, dc, dd, 1);
        tests++; if (obs_ready !== 4'b1000) begin fails++; $display("FAIL bp_release_ready: got %b expected 1000", obs_ready); end
        tests++; if (bus.out_sel !== 2'd3 || bus.out_data !== dd) begin fails++; $display("FAIL bp_release: got sel %0d data %h expected sel 3 data %h", bus.out_sel, bus.out_data, dd); end
    endtask

    task automatic test_idle();
        step(1, 4'b0000, da, db, dc, dd, 1);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b expected 0", bus.out_valid); end
        step(1, 4'b1111, da, db, dc, dd, 1);
        tests++; if (bus.out_sel !== 2'd0 || bus.out_valid !== 1'b1) begin fails++; $display("FAIL idle_ptr_hold: got v%b sel %0d expected v1 sel 0", bus.out_valid, bus.out_sel); end
        step(1, 4'b0000, da, db, dc, dd, 1);
        step(1, 4'b0100, da, db, dc, dd, 1);
        tests++; if (obs_ready !== 4'b0100) begin fails++; $display("FAIL idle_single_ready: got %b expected 0100", obs_ready); end
        tests++; if (bus.out_sel !== 2'd2 || bus.out_data !== dc) begin fails++; $display("FAIL idle_single: got sel %0d data %h expected sel 2 data %h", bus.out_sel, bus.out_data, dc); end
    endtask

    task automatic test_reset_mid();
        step(1, 4'b1111, da, db, dc, dd, 1);
        tests++; if (bus.out_valid !== 1'b1 || bus.out_sel !== 2'd3) begin fails++; $display("FAIL rmid_pre: got v%b sel %0d expected v1 sel 3", bus.out_valid, bus.out_sel); end
        step(0, 4'b1111, da, db, dc, dd, 0);
        tests++; if (obs_ready !== 4'b0000) begin fails++; $display("FAIL rmid_ready: got %b expected 0000", obs_ready); end
        tests++; if (bus.out_valid !== 1'b0 || bus.out_sel !== 2'd0 || bus.out_data !== '0) begin fails++; $display("FAIL rmid_clear: got v%b sel %0d data %h expected v0 sel 0 data 0", bus.out_valid, bus.out_sel, bus.out_data); end
        step(1, 4'b1111, da, db, dc, dd, 1);
        tests++; if (obs_ready !== 4'b0001) begin fails++; $display("FAIL rmid_first_ready: got %b expected 0001", obs_ready); end
        tests++; if (bus.out_sel !== 2'd0 || bus.out_data !== da) begin fails++; $display("FAIL rmid_first: got sel %0d data %h expected sel 0 data %h", bus.out_sel, bus.out_data, da); end
    endtask

    task automatic test_random_stress();
        logic [3:0]   pend;
        logic [W-1:0] pdata [4];
        int           waitcnt [4];
        item_t        q [$];
        item_t        it;
        bit           ordy;
        int           gidx;
        pend = '0;
        for (int i = 0; i < 4; i++) begin pdata[i] = '0; waitcnt[i] = 0; end
        step(0, 4'b0000, da, db, dc, dd, 1);
        for (int cyc = 0; cyc < 10000; cyc++) begin
            // Pending requesters hold data; idle ones may raise a new request,
            // and occasionally a pending one withdraws without a handshake.
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i]  = 1'b1;
                    pdata[i] = W'($urandom);
                end else if (pend[i] && $urandom_range(31, 0) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            ordy = ($urandom_range(3, 0) != 0);
            step(1, pend, pdata[0], pdata[1], pdata[2], pdata[3], ordy);

            tests++; if (obs_ready !== exp_ready) begin fails++; $display("FAIL st_ready[%0d]: got %b expected %b", cyc, obs_ready, exp_ready); end
            tests++; if ($countones(obs_ready) > 1 || (obs_ready & ~pend) != 4'b0000) begin fails++; $display("FAIL st_onehot[%0d]: got %b expected one-hot within %b", cyc, obs_ready, pend); end

            if (obs_ovalid && ordy) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL st_dup[%0d]: got pop with empty scoreboard expected no output", cyc);
                end else begin
                    it = q.pop_front();
                    if (obs_osel !== 2'(it.sel) || obs_odata !== it.data) begin
                        fails++; $display("FAIL st_data[%0d]: got sel %0d data %h expected sel %0d data %h", cyc, obs_osel, obs_odata, it.sel, it.data);
                    end
                end
            end

            gidx = -1;
            for (int i = 0; i < 4; i++) if (obs_ready[i] && pend[i]) gidx = i;
            for (int i = 0; i < 4; i++) if (!pend[i]) waitcnt[i] = 0;
            if (gidx >= 0) begin
                it.sel  = gidx;
                it.data = pdata[gidx];
                q.push_back(it);
                for (int i = 0; i < 4; i++) begin
                    if (i == gidx) begin
                        tests++; if (waitcnt[i] > 3) begin fails++; $display("FAIL st_fair[%0d]: req %0d got %0d other grants expected at most 3", cyc, i, waitcnt[i]); end
                        waitcnt[i] = 0;
                    end else if (pend[i]) begin
                        waitcnt[i]++;
                    end
                end
                pend[gidx] = 1'b0;
            end

            tests++; if (bus.out_valid !== m_valid) begin fails++; $display("FAIL st_valid[%0d]: got %b expected %b", cyc, bus.out_valid, m_valid); end
            tests++; if (q.size() != (bus.out_valid === 1'b1 ? 1 : 0)) begin fails++; $display("FAIL st_loss[%0d]: got %0d queued with out_valid %b expected 1 per valid", cyc, q.size(), bus.out_valid); end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = '0;
        bus.in_data0  = '0;
        bus.in_data1  = '0;
        bus.in_data2  = '0;
        bus.in_data3  = '0;
        bus.out_ready = 1'b0;
        m_ptr = 0; m_valid = 0; m_data = '0; m_sel = 0;
        da = 4'hA; db = 4'hB; dc = 4'hC; dd = 4'hD;

        test_reset();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_idle();
        test_reset_mid();
        test_random_stress();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter_4.md
Name: rr_mux_arbiter_4

Overview:
- Shares one 4:1 AND-OR mux datapath among four valid/ready requesters using round-robin arbitration.
- Output is a single registered valid/ready stream that carries the winning requester's data and its index.
- Sits between four producer streams and one downstream consumer.
- Sustains one transfer per cycle with one cycle of latency.

Parameters:
- WIDTH, 4, data width of every requester and of the output.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  4  bit i set: requester i has data.
- in_data0  input  WIDTH  requester 0 data.
- in_data1  input  WIDTH  requester 1 data.
- in_data2  input  WIDTH  requester 2 data.
- in_data3  input  WIDTH  requester 3 data.
- in_ready  output  4  bit i set: requester i is accepted this cycle (one-hot or zero).
- out_valid  output  1  output register holds a transfer.
- out_data  output  WIDTH  data of the granted requester.
- out_sel  output  2  index of the requester that produced out_data.
- out_ready  input  1  consumer accepts the output this cycle.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous, active-low: sampled only on clk rising edge while rst_n = 0.
- Reset values:
  - out_valid = 0, out_data = 0, out_sel = 0.
  - Priority pointer ptr = 0, so requester 0 has highest priority first.
- Reset effects:
  - in_ready is forced to 4'b0000 while rst_n = 0.
  - A transfer pending in the output register at reset is discarded.
- load_en = ~out_valid | out_ready. The output register may accept a new item only when load_en = 1.
- Grant (combinational):
  - Scan requesters in order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first requester with in_valid set wins; its index is g.
  - grant_onehot = 1 << g; it is 0 if no in_valid is set.
  - in_ready = grant_onehot when load_en = 1, otherwise 0.
  - in_ready never depends on a requester's own in_valid in a way that creates a loop. in_ready depends on out_valid, out_ready, in_valid and ptr only.
- On clk edge with load_en = 1 and any in_valid set:
  - out_valid <= 1.
  - out_data <= mux of in_data0..3 by g. The mux is AND-OR built: each in_data is masked by the replicated grant bit, then the results are ORed.
  - out_sel <= g.
  - ptr <= g + 1, wrapping 3 -> 0.
- On clk edge with load_en = 1 and no in_valid set:
  - out_valid <= 0.
  - out_data and out_sel are don't-care; hold their previous values.
  - ptr is unchanged.
- On clk edge with load_en = 0 (stall, out_valid = 1 and out_ready = 0):
  - out_valid, out_data, out_sel and ptr all hold.
- Latency: exactly one cycle from the in_valid & in_ready handshake to out_valid.
- Throughput: one transfer per cycle when out_ready is held high.
- Fairness:
  - A requester holding in_valid continuously is granted within at most 4 transfers.
  - Requesters granted back-to-back are never the same one while another requester is pending.
- Simultaneous events:
  - An output pop (out_ready = 1) and a new load happen in the same cycle; no bubble.
- Requester protocol:
  - Requesters must hold in_valid and data stable until in_ready is seen.
  - Dropping in_valid without a handshake is tolerated: it is simply not granted, and there is no corruption.
- Width rule: ptr and out_sel are 2 bits; all index arithmetic is modulo 4.

Decomposition:
- Shared package rr_mux_pkg:
  - N_REQ = 4.
  - SEL_W = 2.
  - typedef sel_t as logic [SEL_W-1:0].
- One natural sub-module, rr_grant_4:
  - Purely combinational.
  - Inputs: req[3:0] and ptr.
  - Outputs: grant_onehot[3:0], g, any_req.
- The top contains the AND-OR mux, the output register, ptr and the handshake logic.

Test Plan:
- Reset, then in_valid = 4'b1111, in_data0..3 = a, b, c, d, out_ready = 1:
  - First four outputs are (sel, data) = (0,a), (1,b), (2,c), (3,d).
  - The fifth output is (0,a).
  - out_valid stays 1 every cycle.
- ptr = 2 (after granting requester 1), in_valid = 4'b0011:
  - Next grant is requester 0 (wrap from 2 -> 3 -> 0), out_sel = 0.
  - Then requester 1, out_sel = 1.
- Backpressure: out_valid = 1 with out_sel = 2, data c, out_ready = 0 for 3 cycles, in_valid = 4'b1111:
  - in_ready = 0 and out_data/out_sel/ptr hold throughout.
  - When out_ready = 1, the next output is out_sel = 3, data d.
- Idle: in_valid = 0 with out_ready = 1:
  - out_valid drops to 0 the next cycle and ptr is unchanged.
  - Then in_valid = 4'b0100 gives out_sel = 2 one cycle later.
- Reset mid-operation: rst_n = 0 for one edge while out_valid = 1 and out_sel = 3:
  - Next cycle out_valid = 0, out_sel = 0, out_data = 0, in_ready = 0.
  - After release, with in_valid = 4'b1111, requester 0 is granted first.
- Random stress, 10000 cycles with random in_valid, data and out_ready:
  - Scoreboard checks no loss or duplication, out_data matching the in_data of out_sel, and in_ready at most one-hot.
  - Fairness check: at most 3 other grants between successive grants to a continuously requesting input.
